interboard_output: RTL and testbench
====================================

// Module: interboard_output
// PURPOSE
//  Transmit side of the board-to-board link; its peer is interboard_input on the neighbouring board.
//  - Drains the local outbound FIFO (normal mode, 1-cycle read latency) and drives 11-bit words with a valid strobe.
//  - Honours the peer's registered flow-control line (read), which is synchronous to transmit_clk.
//  - Holds off after reset until the link has been seen ready for LINK_WAIT consecutive cycles.
// PARAMETERS
//  WORD_W     11  link word width (interboard_pkg::WORD_W)
//  LINK_WAIT  16  consecutive ready_q cycles required before first transfer after reset
//  CNT_W      32  width of tx_count / stall_count
// PORTS
//  transmit_clk  in   1       link clock, also forwarded to the peer
//  reset         in   1       synchronous, active-high
//  fifo_q        in   WORD_W  outbound FIFO read data, valid the cycle after fifo_rdreq
//  fifo_empty    in   1       outbound FIFO empty
//  fifo_rdreq    out  1       FIFO read request (combinational)
//  read_in       in   1       peer flow control: 1 = peer accepting, 0 = stop
//  tx_data       out  WORD_W  word to peer (registered)
//  tx_valid      out  1       tx_data valid this cycle (registered)
//  link_up       out  1       LINK_WAIT satisfied; transfers permitted
//  tx_count      out  CNT_W   words sent since reset; wraps
//  stall_count   out  CNT_W   cycles with FIFO non-empty but blocked by peer; saturates at all-ones
// BEHAVIOUR
//  Reset (sync, active-high, clock transmit_clk): state=LINKWAIT.
//  - All outputs 0 on the next edge, including tx_data; fifo_rdreq=0 while reset is high.
//  - ready_q, rd_pend and the link counter are cleared.
//  - A word already popped from the FIFO (rd_pend) is discarded; no recovery is attempted.
//  ready_q: read_in registered once. It is the only use of read_in.
//  FSM:
//  - LINKWAIT: count++ while ready_q=1, otherwise clear.
//    - count==LINK_WAIT-1 and ready_q=1 -> SEND; link_up<=1.
//  - SEND: fifo_rdreq = ready_q & ~fifo_empty.
//    - ready_q=0 -> HOLD.
//  - HOLD: fifo_rdreq=0.
//    - ready_q=1 -> SEND.
//  - Once up, the link never returns to LINKWAIT except via reset.
//  Pipeline (fixed latency 2):
//  - Cycle n: fifo_rdreq=1.
//  - Edge ending n: rd_pend<=1.
//  - Cycle n+1: fifo_q valid.
//  - Edge ending n+1: tx_data<=fifo_q, tx_valid<=1.
//  - tx_valid<=rd_pend every cycle; tx_data holds its last value when rd_pend=0.
//  - Back-to-back pops give one tx_valid beat per cycle, with no bubbles.
//  Flow-control bound:
//  - read_in first low in cycle k -> ready_q low in k+1 -> no rdreq from k+1.
//  - tx_valid may be 1 in k+1 and k+2 only; it is 0 from k+3 until read_in returns.
//  - This is at most 2 in-flight words, covered by the peer's slack (STOP_TRIGGER=252 of 256).
//  Counters:
//  - tx_count += 1 on each tx_valid beat (mod 2^CNT_W).
//  - stall_count += 1 when link_up & ~fifo_empty & ~ready_q, held at max once saturated.
//  Simultaneous events: read_in dropping on the same cycle as a rdreq does not cancel that rdreq; the word is sent.
//  fifo_empty rising while rd_pend=1: the pending word is still sent.
//  fifo_rdreq is never asserted when fifo_empty=1 (no underflow).
// STRUCTURE
//  interboard_pkg holds the constants shared with interboard_input:
//  - WORD_W=11, FIFO_DEPTH=256, STOP_TRIGGER=252, START_TRIGGER=251, MAX_INFLIGHT=2.
//  - typedef enum {LINKWAIT,SEND,HOLD} tx_state_t.
//  Sub-module interboard_tx_pipe holds the rd_pend/tx_data/tx_valid stage and tx_count; the FSM and link counter stay here.
// TESTING
//  1. Reset high 3 cycles with read_in=1 and FIFO holding 5 words.
//     -> tx_valid=0 and fifo_rdreq=0 until link_up.
//     -> link_up rises 16 cycles after ready_q first goes 1.
//  2. read_in=1 throughout; FIFO loaded 0x001..0x00A.
//     -> 10 consecutive tx_valid beats, in order, 2 cycles after the first rdreq.
//     -> tx_count=10 afterwards.
//  3. Streaming, then read_in low in cycle k.
//     -> at most 2 beats, in k+1 and k+2, then tx_valid=0.
//     -> read_in high again -> streaming resumes with no word lost or duplicated.
//  4. read_in toggling each cycle during LINKWAIT.
//     -> link_up stays 0; counter restarts on each drop.
//  5. FIFO empties mid-stream.
//     -> rdreq never asserted while fifo_empty=1.
//     -> stall_count unchanged while the FIFO is empty.
//  6. Reset asserted while rd_pend=1.
//     -> next cycle tx_valid=0 and all counters=0; the link re-runs LINKWAIT.

Source files
------------

// File: rtl/interboard_pkg.sv
// Constants and types shared by both ends of the board-to-board link.
package interboard_pkg;
  localparam int WORD_W        = 11;
  localparam int FIFO_DEPTH    = 256;
  localparam int STOP_TRIGGER  = 252;
  localparam int START_TRIGGER = 251;
  localparam int MAX_INFLIGHT  = 2;

  typedef enum logic [1:0] {
    LINKWAIT,
    SEND,
    HOLD
  } tx_state_t;
endpackage

// File: rtl/interboard_tx_pipe.sv
// Two-stage FIFO-to-link data path: pending pop, then registered word.
module interboard_tx_pipe #(
  parameter int W  = 11,
  parameter int CW = 32
) (
  input  logic          transmit_clk,
  input  logic          reset,
  input  logic          rdreq,
  input  logic [W-1:0]  fifo_q,
  output logic [W-1:0]  tx_data,
  output logic          tx_valid,
  output logic [CW-1:0] tx_count
);
  logic rd_pend;

  // A pop in flight at reset is dropped along with rd_pend.
  always_ff @(posedge transmit_clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_count <= '0;
    end else begin
      rd_pend  <= rdreq;
      tx_valid <= rd_pend;
      if (rd_pend) begin
        tx_data  <= fifo_q;
        tx_count <= tx_count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/interboard_output.sv
// Transmit side of the board link: link bring-up, flow control, stats.
module interboard_output #(
  parameter int WORD_W    = interboard_pkg::WORD_W,
  parameter int LINK_WAIT = 16,
  parameter int CNT_W     = 32
) (
  input  logic              transmit_clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  input  logic              read_in,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              link_up,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  stall_count
);
  import interboard_pkg::*;

  localparam int LC_W = $clog2(LINK_WAIT + 1);

  tx_state_t       state;
  logic            ready_q;
  logic [LC_W-1:0] link_cnt;
  logic            stall;

  assign fifo_rdreq = ~reset & (state == SEND)
                    & ready_q & ~fifo_empty;

  assign stall = link_up & ~fifo_empty & ~ready_q;

  always_ff @(posedge transmit_clk) begin
    if (reset) begin
      state       <= LINKWAIT;
      ready_q     <= 1'b0;
      link_cnt    <= '0;
      link_up     <= 1'b0;
      stall_count <= '0;
    end else begin
      ready_q <= read_in;
      if (stall && !(&stall_count))
        stall_count <= stall_count + 1'b1;
      unique case (state)
        LINKWAIT: begin
          if (ready_q) begin
            link_cnt <= link_cnt + 1'b1;
            if (link_cnt == LC_W'(LINK_WAIT - 1)) begin
              state   <= SEND;
              link_up <= 1'b1;
            end
          end else begin
            link_cnt <= '0;
          end
        end
        SEND: if (!ready_q) state <= HOLD;
        HOLD: if (ready_q) state <= SEND;
        default: state <= LINKWAIT;
      endcase
    end
  end

  interboard_tx_pipe #(
    .W  (WORD_W),
    .CW (CNT_W)
  ) u_pipe (
    .transmit_clk (transmit_clk),
    .reset        (reset),
    .rdreq        (fifo_rdreq),
    .fifo_q       (fifo_q),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_count     (tx_count)
  );
endmodule

// File: tb/tb_interboard_output.sv
// Directed bench for interboard_output with a 1-cycle-latency FIFO model.
module tb_interboard_output;
  logic        transmit_clk;
  logic        reset;
  logic [10:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic        read_in;
  logic [10:0] tx_data;
  logic        tx_valid;
  logic        link_up;
  logic [31:0] tx_count;
  logic [31:0] stall_count;

  interboard_output dut (
    .transmit_clk (transmit_clk),
    .reset        (reset),
    .fifo_q       (fifo_q),
    .fifo_empty   (fifo_empty),
    .fifo_rdreq   (fifo_rdreq),
    .read_in      (read_in),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .link_up      (link_up),
    .tx_count     (tx_count),
    .stall_count  (stall_count)
  );

  initial begin
    transmit_clk = 1'b0;
    forever #5 transmit_clk = ~transmit_clk;
  end

  logic [10:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  initial fifo_q = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge transmit_clk) begin
    if (fifo_rdreq) begin
      fifo_q <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [10:0] rx_mem [128];
  int rx_n = 0;
  int viol = 0;
  always @(negedge transmit_clk) begin
    #2;
    if (fifo_rdreq && fifo_empty) viol++;
    if (tx_valid && rx_n < 128) begin
      rx_mem[rx_n] = tx_data;
      rx_n++;
    end
  end

  typedef struct {
    logic        rd;
    logic        link;
    logic        rdreq;
    logic        valid;
    logic [10:0] data;
    int          reps;
  } vec_t;
  vec_t tv [8];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  task automatic push(input logic [10:0] v);
    mem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge transmit_clk);
    reset = 1'b1;
    repeat (3) @(negedge transmit_clk);
    reset = 1'b0;
  endtask

  task automatic wait_link(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (link_up) begin
        n = i;
        break;
      end
      @(negedge transmit_clk);
    end
  endtask

  task automatic check_rx(input string name, input int base,
                          input int cnt, input logic [10:0] first);
    logic [10:0] w;
    chk({name, "_count"}, rx_n - base, cnt);
    for (int i = 0; i < cnt; i++) begin
      w = first + 11'(i);
      chk({name, "_word"}, {21'd0, rx_mem[base + i]}, {21'd0, w});
    end
  endtask

  int n;
  int base;
  logic [31:0] cnt0;
  logic [31:0] st0;

  initial begin
    reset   = 1'b1;
    read_in = 1'b1;

    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 17};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 11'h000, 2};
    tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 11'h0A1, 1};
    tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 11'h0A2, 1};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 11'h0A3, 1};
    tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h0A4, 1};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h0A5, 1};
    tv[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'h0A5, 3};

    // Bring-up with five words waiting, then drain them.
    for (int i = 0; i < 5; i++) push(11'h0A1 + 11'(i));
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < tv[i].reps; r++) begin
        read_in = tv[i].rd;
        #1;
        chk("t1_link_up", {31'd0, link_up}, {31'd0, tv[i].link});
        chk("t1_rdreq", {31'd0, fifo_rdreq}, {31'd0, tv[i].rdreq});
        chk("t1_valid", {31'd0, tx_valid}, {31'd0, tv[i].valid});
        chk("t1_data", {21'd0, tx_data}, {21'd0, tv[i].data});
        @(negedge transmit_clk);
      end
    end
    chk("t1_tx_count", tx_count, 32'd5);

    // Toggling ready during bring-up keeps restarting the counter.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      read_in = (i % 2 == 0);
      #1;
      chk("t4_link_low", {31'd0, link_up}, 32'd0);
      @(negedge transmit_clk);
    end
    read_in = 1'b1;
    wait_link(n);
    chk("t4_link_latency", n, 32'd17);

    // Ten words streamed back to back.
    @(negedge transmit_clk);
    for (int i = 0; i < 10; i++) push(11'h001 + 11'(i));
    #1;
    chk("t2_first_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge transmit_clk);
      #1;
      chk("t2_valid", {31'd0, tx_valid},
          {31'd0, (j >= 2 && j <= 11)});
      if (j >= 2 && j <= 11)
        chk("t2_data", {21'd0, tx_data}, j - 1);
    end
    chk("t2_tx_count", tx_count, 32'd10);

    // Peer stops for five cycles mid-stream.
    cnt0 = tx_count;
    st0  = stall_count;
    base = rx_n;
    for (int c = 0; c < 36; c++) begin
      @(negedge transmit_clk);
      if (c == 0)
        for (int i = 0; i < 20; i++) push(11'h100 + 11'(i));
      if (c == 5) read_in = 1'b0;
      if (c == 10) read_in = 1'b1;
      #1;
      if (c == 6 || c == 7)
        chk("t3_inflight_beat", {31'd0, tx_valid}, 32'd1);
      if (c >= 8 && c <= 13)
        chk("t3_stopped", {31'd0, tx_valid}, 32'd0);
    end
    check_rx("t3_rx", base, 20, 11'h100);
    chk("t3_tx_count", tx_count - cnt0, 32'd20);
    chk("t3_stall", stall_count - st0, 32'd5);

    // FIFO runs dry while the peer also stops.
    st0  = stall_count;
    base = rx_n;
    for (int c = 0; c < 20; c++) begin
      @(negedge transmit_clk);
      if (c == 0)
        for (int i = 0; i < 3; i++) push(11'h200 + 11'(i));
      if (c == 6) read_in = 1'b0;
      if (c == 10) read_in = 1'b1;
      if (c == 12) begin
        push(11'h203);
        push(11'h204);
      end
    end
    #1;
    check_rx("t5_rx", base, 5, 11'h200);
    chk("t5_stall", stall_count - st0, 32'd0);

    // Reset while a popped word is in flight.
    base = rx_n;
    @(negedge transmit_clk);
    for (int i = 0; i < 4; i++) push(11'h300 + 11'(i));
    #1;
    chk("t6_rdreq", {31'd0, fifo_rdreq}, 32'd1);
    @(negedge transmit_clk);
    reset = 1'b1;
    #1;
    chk("t6_rdreq_in_reset", {31'd0, fifo_rdreq}, 32'd0);
    @(negedge transmit_clk);
    reset = 1'b0;
    #1;
    chk("t6_valid", {31'd0, tx_valid}, 32'd0);
    chk("t6_tx_count", tx_count, 32'd0);
    chk("t6_stall", stall_count, 32'd0);
    chk("t6_link_up", {31'd0, link_up}, 32'd0);
    chk("t6_data", {21'd0, tx_data}, 32'd0);
    wait_link(n);
    chk("t6_link_latency", n, 32'd17);
    repeat (8) @(negedge transmit_clk);
    #1;
    check_rx("t6_rx", base, 3, 11'h301);
    chk("t6_tx_count_after", tx_count, 32'd3);

    chk("no_underflow", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
